// File: rtl/adder_sub_pipe_32_pkg.sv
//------------------------------------------------------------------------------
// Module  : adder_sub_pipe_32_pkg
// Brief   : Shared constants and the S1 stage record for the pipelined subtractor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package adder_sub_pipe_32_pkg;

    localparam int HALF_DEFAULT = 16;

    // Everything S2 needs from S1: upper operand halves plus the finished low slice.
    typedef struct packed {
        logic                    valid;
        logic [HALF_DEFAULT-1:0] a_hi;
        logic [HALF_DEFAULT-1:0] b_hi;
        logic [HALF_DEFAULT-1:0] d_lo;
        logic                    b_mid;
    } stage_t;

endpackage

`default_nettype wire

// File: rtl/adder_sub_pipe_32_sub_16bit.sv
//------------------------------------------------------------------------------
// Module  : sub_16bit
// Brief   : Combinational ripple-borrow subtractor, d = a - b - bin.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sub_16bit #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic w_borrow;

    always_comb begin
        w_borrow = bin;
        d        = '0;
        for (int i = 0; i < W; i++) begin
            d[i]     = a[i] ^ b[i] ^ w_borrow;
            // Borrow when this bit of a is smaller than b plus the incoming borrow.
            w_borrow = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow);
        end
        bout = w_borrow;
    end

endmodule

`default_nettype wire

// File: rtl/adder_sub_pipe_32.sv
//------------------------------------------------------------------------------
// Module  : adder_sub_pipe_32
// Brief   : Two-stage valid/ready pipelined subtractor, low slice in S1, high in S2.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adder_sub_pipe_32
    import adder_sub_pipe_32_pkg::*;
#(
    parameter int HALF = HALF_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*HALF-1:0] a,
    input  logic [2*HALF-1:0] b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*HALF-1:0] d,
    output logic              bout,
    output logic              ovf
);

    localparam int W = 2 * HALF;

    // The S1 record is sized by HALF_DEFAULT, so other slice widths are rejected.
    generate
        if (HALF != HALF_DEFAULT) begin : g_half_check
            $error("adder_sub_pipe_32: HALF must equal HALF_DEFAULT");
        end
    endgenerate

    stage_t          r_s1;
    logic            r_s2_v;
    logic [W-1:0]    r_d;
    logic            r_bout;
    logic            r_ovf;

    logic            w_s2_load;
    logic            w_s1_load;
    logic [HALF-1:0] w_d_lo;
    logic            w_b_mid;
    logic [HALF-1:0] w_d_hi;
    logic            w_bout_hi;
    logic            w_ovf;

    assign w_s2_load = !r_s2_v || out_ready;
    assign w_s1_load = !r_s1.valid || w_s2_load;
    assign in_ready  = w_s1_load;

    sub_16bit #(.W(HALF)) u_sub_lo (
        .a    (a[HALF-1:0]),
        .b    (b[HALF-1:0]),
        .bin  (bin),
        .d    (w_d_lo),
        .bout (w_b_mid)
    );

    sub_16bit #(.W(HALF)) u_sub_hi (
        .a    (r_s1.a_hi),
        .b    (r_s1.b_hi),
        .bin  (r_s1.b_mid),
        .d    (w_d_hi),
        .bout (w_bout_hi)
    );

    assign w_ovf = (r_s1.a_hi[HALF-1] != r_s1.b_hi[HALF-1]) &&
                   (w_d_hi[HALF-1]    != r_s1.a_hi[HALF-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
        end else if (w_s1_load) begin
            r_s1.valid <= in_valid;
            if (in_valid) begin
                r_s1.a_hi  <= a[W-1:HALF];
                r_s1.b_hi  <= b[W-1:HALF];
                r_s1.d_lo  <= w_d_lo;
                r_s1.b_mid <= w_b_mid;
            end
        end
    end

    // Bubbles advance only the valid bit so the last result stays on d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v <= 1'b0;
            r_d    <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_v <= r_s1.valid;
            if (r_s1.valid) begin
                r_d    <= {w_d_hi, r_s1.d_lo};
                r_bout <= w_bout_hi;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign d         = r_d;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adder_sub_pipe_32.sv
//------------------------------------------------------------------------------
// Module  : tb_adder_sub_pipe_32
// Brief   : Self-checking bench for adder_sub_pipe_32 with an arithmetic reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_adder_sub_pipe_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        bout;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    // Each entry is {ovf, bout, d}.
    logic [33:0] exp_q[$];
    logic [33:0] got_q[$];

    adder_sub_pipe_32 #(.HALF(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
        longint ua, ub, sa, sb, ud, sd;
        logic [31:0] rd;
        logic rb, ro;
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ud = ua - ub - longint'(mbin);
        sd = sa - sb - longint'(mbin);
        rd = ud[31:0];
        rb = (ua < ub + longint'(mbin));
        ro = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {ro, rb, rd};
    endfunction

    // Advance one clock, logging transfers as seen just before the edge.
    task automatic step();
        @(negedge clk);
        if (in_valid && in_ready)   exp_q.push_back(model(a, b, bin));
        if (out_valid && out_ready) got_q.push_back({ovf, bout, d});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (d !== 32'h0) $display("FAIL reset_d got %h want 00000000", d); else n_pass++;
        n_checks++; if (bout !== 1'b0) $display("FAIL reset_bout got %b want 0", bout); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] va[4], vb[4], vd[4];
        logic        vbin[4], vbo[4], vov[4];
        va = '{32'd5, 32'd0, 32'h0001_0000, 32'h8000_0000};
        vb = '{32'd3, 32'd1, 32'h0,         32'h1};
        vbin = '{1'b0, 1'b0, 1'b1, 1'b0};
        vd = '{32'h2, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h7FFF_FFFF};
        vbo = '{1'b0, 1'b1, 1'b0, 1'b0};
        vov = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            clear_q();
            out_ready = 1'b1;
            in_valid  = 1'b1;
            a = va[i]; b = vb[i]; bin = vbin[i];
            step();
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL dir%0d_latency_early out_valid %b want 0", i, out_valid); else n_pass++;
            step();
            n_checks++; if (out_valid !== 1'b1) $display("FAIL dir%0d_latency out_valid %b want 1", i, out_valid); else n_pass++;
            n_checks++; if (d !== vd[i]) $display("FAIL dir%0d_d got %h want %h", i, d, vd[i]); else n_pass++;
            n_checks++; if (bout !== vbo[i]) $display("FAIL dir%0d_bout got %b want %b", i, bout, vbo[i]); else n_pass++;
            n_checks++; if (ovf !== vov[i]) $display("FAIL dir%0d_ovf got %b want %b", i, ovf, vov[i]); else n_pass++;
            step();
            n_checks++; if (out_valid !== 1'b0) $display("FAIL dir%0d_drain out_valid %b want 0", i, out_valid); else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        logic [31:0] pa[3], pb[3];
        logic        pbin[3];
        logic [31:0] held_d;
        int idx;
        int waits;
        for (int i = 0; i < 3; i++) begin
            pa[i] = $urandom; pb[i] = $urandom; pbin[i] = 1'($urandom_range(0, 1));
        end
        clear_q();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            a = pa[idx]; b = pb[idx]; bin = pbin[idx];
            step();
            idx = exp_q.size();
        end
        a = pa[idx]; b = pb[idx]; bin = pbin[idx];
        #1;
        n_checks++; if (exp_q.size() != 2) $display("FAIL bp_accepted got %0d want 2", exp_q.size()); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (exp_q.size() > 0 && d !== exp_q[0][31:0]) $display("FAIL bp_head_d got %h want %h", d, exp_q[0][31:0]); else n_pass++;
        held_d = d;
        step();
        step();
        n_checks++; if ({ovf, bout, d} !== {exp_q[0][33:32], held_d}) $display("FAIL bp_hold got %h want %h", {ovf, bout, d}, {exp_q[0][33:32], held_d}); else n_pass++;
        out_ready = 1'b1;
        waits = 0;
        while (got_q.size() < 3 && waits < 20) begin
            if (idx < 3) begin
                in_valid = 1'b1;
                a = pa[idx]; b = pb[idx]; bin = pbin[idx];
            end else begin
                in_valid = 1'b0;
            end
            step();
            idx = exp_q.size();
            waits++;
        end
        in_valid = 1'b0;
        n_checks++; if (got_q.size() != 3) $display("FAIL bp_result_count got %0d want 3", got_q.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [33:0] want;
            want = model(pa[i], pb[i], pbin[i]);
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== want)
                $display("FAIL bp_order%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 34'h0, want);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int stalls;
        clear_q();
        out_ready = 1'b1;
        stalls = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
            #1;
            if (!in_ready) stalls++;
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (stalls != 0) $display("FAIL b2b_stalls got %0d want 0", stalls); else n_pass++;
        n_checks++; if (got_q.size() != 14) $display("FAIL b2b_results_in_flight got %0d want 14", got_q.size()); else n_pass++;
        step();
        step();
        n_checks++; if (got_q.size() != 16) $display("FAIL b2b_results got %0d want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data%0d got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_random();
        int waits;
        clear_q();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       begin a = 32'h8000_0000 ^ $urandom_range(0, 3); b = $urandom_range(0, 3); end
                1:       begin a = $urandom_range(0, 3); b = 32'h7FFF_FFFF - $urandom_range(0, 3); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            bin = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waits = 0;
        while (got_q.size() < exp_q.size() && waits < 10) begin
            step();
            waits++;
        end
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_data%0d got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        clear_q();
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL rstmid_full out_valid %b in_ready %b want 1 0", out_valid, in_ready); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if ({ovf, bout, d} !== 34'h0) $display("FAIL rstmid_data got %h want 0", {ovf, bout, d}); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        clear_q();
        for (int c = 0; c < 6; c++) step();
        n_checks++; if (got_q.size() != 0) $display("FAIL rstmid_stale got %0d results want 0", got_q.size()); else n_pass++;
        clear_q();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
